l2_request_sequencer: RTL and testbench

- Upstream feeder for the L2 cache.
- Accepts trace commands (code + address) from the testbench/trace reader and buffers them in a small FIFO.
- Issues them one at a time to the L2 with a valid/ready handshake, then waits for the L2's hit/miss response.
- Keeps read/write/hit/miss statistics and handles the clear (8) and print (9) control commands locally.

---
 rtl/l2_request_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_l2_request_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_sequencer.sv
// Upstream feeder for the L2: buffers trace commands, issues them one at a time
// over a valid/ready handshake, waits for hit/miss, and keeps access statistics.
module l2_request_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic [3:0]             cmdCode,
    input  logic [ADDR_WIDTH-1:0]  cmdAddress,
    output logic                   reqValid,
    input  logic                   reqReady,
    output logic [3:0]             reqOp,
    output logic [ADDR_WIDTH-1:0]  reqAddress,
    input  logic                   respValid,
    input  logic                   respHit,
    output logic [COUNT_WIDTH-1:0] readCount,
    output logic [COUNT_WIDTH-1:0] writeCount,
    output logic [COUNT_WIDTH-1:0] hitCount,
    output logic [COUNT_WIDTH-1:0] missCount,
    output logic [COUNT_WIDTH-1:0] invalidCount,
    output logic                   clearDone,
    output logic                   printReq,
    output logic                   busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [3:0] CODE_READ    = 4'd0;
    localparam logic [3:0] CODE_WRITE   = 4'd1;
    localparam logic [3:0] CODE_IFETCH  = 4'd2;
    localparam logic [3:0] CODE_L2_MAX  = 4'd6;
    localparam logic [3:0] CODE_ILLEGAL = 4'd7;
    localparam logic [3:0] CODE_CLEAR   = 4'd8;
    localparam logic [3:0] CODE_PRINT   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [3:0]            r_fifo_code [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;

    logic                   r_req_valid;
    logic [3:0]             r_req_op;
    logic [ADDR_WIDTH-1:0]  r_req_addr;
    logic                   r_clear_done;
    logic                   r_print_req;
    logic [COUNT_WIDTH-1:0] r_read_cnt;
    logic [COUNT_WIDTH-1:0] r_write_cnt;
    logic [COUNT_WIDTH-1:0] r_hit_cnt;
    logic [COUNT_WIDTH-1:0] r_miss_cnt;
    logic [COUNT_WIDTH-1:0] r_invalid_cnt;

    logic                  w_cmd_illegal;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_push_illegal;
    logic                  w_fifo_empty;
    logic [3:0]            w_head_code;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic                  w_pop;
    logic                  w_load_req;
    logic                  w_do_clear;
    logic                  w_do_print;
    logic                  w_resp_done;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNT_WIDTH'(1);
    endfunction

    // Illegal codes are counted at the input and never occupy a FIFO slot.
    assign w_cmd_illegal  = (cmdCode == CODE_ILLEGAL) || (cmdCode > CODE_PRINT);
    assign cmdReady       = (r_occ < OCC_FULL);
    assign w_accept       = cmdValid && cmdReady;
    assign w_push         = w_accept && !w_cmd_illegal;
    assign w_push_illegal = w_accept && w_cmd_illegal;
    assign w_fifo_empty   = (r_occ == '0);
    assign w_head_code    = r_fifo_code[r_rd_ptr];
    assign w_head_addr    = r_fifo_addr[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_code[r_wr_ptr] <= cmdCode;
            r_fifo_addr[r_wr_ptr] <= cmdAddress;
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load_req   = 1'b0;
        w_do_clear   = 1'b0;
        w_do_print   = 1'b0;
        w_resp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head_code <= CODE_L2_MAX) begin
                        w_load_req   = 1'b1;
                        w_next_state = ST_ISSUE;
                    end else if (w_head_code == CODE_CLEAR) begin
                        w_do_clear = 1'b1;
                    end else begin
                        w_do_print = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (reqReady) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (respValid) begin
                    w_resp_done  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request payload holds its last value after completion; only a new load changes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req_valid  <= 1'b0;
            r_req_op     <= '0;
            r_req_addr   <= '0;
            r_clear_done <= 1'b0;
            r_print_req  <= 1'b0;
        end else begin
            r_req_valid  <= (w_next_state == ST_ISSUE);
            r_clear_done <= w_do_clear;
            r_print_req  <= w_do_print;
            if (w_load_req) begin
                r_req_op   <= w_head_code;
                r_req_addr <= w_head_addr;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_read_cnt  <= '0;
            r_write_cnt <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else if (w_do_clear) begin
            r_read_cnt  <= '0;
            r_write_cnt <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else if (w_resp_done) begin
            if ((r_req_op == CODE_READ) || (r_req_op == CODE_IFETCH)) begin
                r_read_cnt <= sat_inc(r_read_cnt);
            end
            if (r_req_op == CODE_WRITE) begin
                r_write_cnt <= sat_inc(r_write_cnt);
            end
            if (r_req_op <= CODE_IFETCH) begin
                if (respHit) begin
                    r_hit_cnt <= sat_inc(r_hit_cnt);
                end else begin
                    r_miss_cnt <= sat_inc(r_miss_cnt);
                end
            end
        end
    end

    // An illegal code accepted in the clear cycle arrived after the clear, so it survives it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_invalid_cnt <= '0;
        end else if (w_do_clear) begin
            r_invalid_cnt <= w_push_illegal ? COUNT_WIDTH'(1) : '0;
        end else if (w_push_illegal) begin
            r_invalid_cnt <= sat_inc(r_invalid_cnt);
        end
    end

    assign reqValid     = r_req_valid;
    assign reqOp        = r_req_op;
    assign reqAddress   = r_req_addr;
    assign clearDone    = r_clear_done;
    assign printReq     = r_print_req;
    assign readCount    = r_read_cnt;
    assign writeCount   = r_write_cnt;
    assign hitCount     = r_hit_cnt;
    assign missCount    = r_miss_cnt;
    assign invalidCount = r_invalid_cnt;
    assign busy         = !w_fifo_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_l2_request_sequencer.sv
// Bench for l2_request_sequencer: directed table, hand sequences for ordering,
// wrap, saturation and reset, and a randomized run against a queue-based model.
module tb_l2_request_sequencer;

    localparam int unsigned AW   = 32;
    localparam int unsigned CW   = 8;
    localparam int          CMAX = 255;

    logic          clock;
    logic          reset;
    logic          cmdValid;
    logic          cmdReady;
    logic [3:0]    cmdCode;
    logic [AW-1:0] cmdAddress;
    logic          reqValid;
    logic          reqReady;
    logic [3:0]    reqOp;
    logic [AW-1:0] reqAddress;
    logic          respValid;
    logic          respHit;
    logic [CW-1:0] readCount;
    logic [CW-1:0] writeCount;
    logic [CW-1:0] hitCount;
    logic [CW-1:0] missCount;
    logic [CW-1:0] invalidCount;
    logic          clearDone;
    logic          printReq;
    logic          busy;

    l2_request_sequencer #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (4),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmdCode     (cmdCode),
        .cmdAddress  (cmdAddress),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqOp       (reqOp),
        .reqAddress  (reqAddress),
        .respValid   (respValid),
        .respHit     (respHit),
        .readCount   (readCount),
        .writeCount  (writeCount),
        .hitCount    (hitCount),
        .missCount   (missCount),
        .invalidCount(invalidCount),
        .clearDone   (clearDone),
        .printReq    (printReq),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
    } txn_t;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] addr;
        bit          hit;
        bit          iss;
        int          rd;
        int          wr;
        int          hs;
        int          ms;
        int          inv;
        int          pr;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   m_rd, m_wr, m_hit, m_miss, m_inv, m_print;
    int   n_print = 0;
    int   n_clear = 0;
    int   n_legal, n_resp;
    bit   prod_done, rnd_abort;
    txn_t exp_q[$];
    vec_t vt[14];
    logic [3:0]  f_op[6];
    logic [31:0] f_ad[6];

    always @(negedge clock) begin
        if (!reset) begin
            if (printReq)  n_print++;
            if (clearDone) n_clear++;
        end
    end

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    function automatic void m_resp(input logic [3:0] op, input bit hit);
        if (op == 4'd0 || op == 4'd2) m_rd = sat(m_rd);
        if (op == 4'd1)               m_wr = sat(m_wr);
        if (op <= 4'd2) begin
            if (hit) m_hit  = sat(m_hit);
            else     m_miss = sat(m_miss);
        end
    endfunction

    function automatic void m_zero();
        m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0; m_inv = 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_read"},    64'(readCount),    64'(m_rd));
        chk({tag, "_write"},   64'(writeCount),   64'(m_wr));
        chk({tag, "_hit"},     64'(hitCount),     64'(m_hit));
        chk({tag, "_miss"},    64'(missCount),    64'(m_miss));
        chk({tag, "_invalid"}, 64'(invalidCount), 64'(m_inv));
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push(input logic [3:0] c, input logic [31:0] a);
        int n;
        n = 0;
        cmdValid = 1'b1; cmdCode = c; cmdAddress = a;
        while (!cmdReady && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (!cmdReady) begin
            total++; bad++;
            $display("FAIL push_timeout: cmdReady still 0 after %0d cycles, expected 1", n);
        end else begin
            @(negedge clock);
        end
        cmdValid = 1'b0;
    endtask

    task automatic do_txn(input logic [3:0] op, input logic [31:0] a,
                          input int hold, input int dly, input bit hit);
        int n;
        n = 0;
        while (!reqValid && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!reqValid) begin
            total++; bad++;
            $display("FAIL req_timeout: reqValid still 0 after %0d cycles waiting for op %0d", n, op);
            return;
        end
        chk("txn_op",   64'(reqOp),      64'(op));
        chk("txn_addr", 64'(reqAddress), 64'(a));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_valid", 64'(reqValid),   64'(1));
            chk("hold_op",    64'(reqOp),      64'(op));
            chk("hold_addr",  64'(reqAddress), 64'(a));
        end
        reqReady = 1'b1;
        @(negedge clock);
        reqReady = 1'b0;
        chk("post_hs_valid", 64'(reqValid), 64'(0));
        for (int i = 1; i < dly; i++) @(negedge clock);
        respValid = 1'b1; respHit = hit;
        @(negedge clock);
        respValid = 1'b0; respHit = 1'b0;
        m_resp(op, hit);
    endtask

    task automatic do_clear();
        int p;
        p = n_clear;
        push(4'd8, 32'h0);
        repeat (3) @(negedge clock);
        chk("clear_pulse", 64'(n_clear), 64'(p + 1));
        m_zero();
        chk_model("clear");
    endtask

    initial begin
        int e_rd, e_wr, e_hs, e_ms, e_inv, e_pr, p0, pc;
        bit seen;

        vt[0]  = '{4'd0,  32'h0000_2000, 1'b1, 1'b1, 1, 0, 1, 0, 0, 0};
        vt[1]  = '{4'd0,  32'h0000_2040, 1'b0, 1'b1, 1, 0, 0, 1, 0, 0};
        vt[2]  = '{4'd1,  32'h8000_0004, 1'b1, 1'b1, 0, 1, 1, 0, 0, 0};
        vt[3]  = '{4'd1,  32'hFFFF_FFFC, 1'b0, 1'b1, 0, 1, 0, 1, 0, 0};
        vt[4]  = '{4'd2,  32'h1234_5678, 1'b1, 1'b1, 1, 0, 1, 0, 0, 0};
        vt[5]  = '{4'd2,  32'h0000_0000, 1'b0, 1'b1, 1, 0, 0, 1, 0, 0};
        vt[6]  = '{4'd3,  32'hDEAD_BEE0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
        vt[7]  = '{4'd4,  32'h0000_0100, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0};
        vt[8]  = '{4'd5,  32'h7FFF_FFFF, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
        vt[9]  = '{4'd6,  32'hA5A5_5A5A, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0};
        vt[10] = '{4'd7,  32'h0000_0040, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
        vt[11] = '{4'd10, 32'h0000_0080, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
        vt[12] = '{4'd15, 32'h0000_00C0, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
        vt[13] = '{4'd9,  32'h0000_0000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1};

        f_op = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6};
        f_ad = '{32'h1000_0000, 32'h1000_0040, 32'h2000_0080,
                 32'h3000_00C0, 32'h4000_0100, 32'h5000_0140};

        reset = 1'b1; cmdValid = 1'b0; cmdCode = '0; cmdAddress = '0;
        reqReady = 1'b0; respValid = 1'b0; respHit = 1'b0;
        m_zero(); m_print = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        chk("rst_reqValid",   64'(reqValid),   64'(0));
        chk("rst_reqOp",      64'(reqOp),      64'(0));
        chk("rst_reqAddress", 64'(reqAddress), 64'(0));
        chk("rst_clearDone",  64'(clearDone),  64'(0));
        chk("rst_printReq",   64'(printReq),   64'(0));
        chk("rst_busy",       64'(busy),       64'(0));
        chk("rst_cmdReady",   64'(cmdReady),   64'(1));
        chk_model("rst");

        // First read, hit two cycles after handshake
        push(4'd0, 32'h0000_1040);
        do_txn(4'd0, 32'h0000_1040, 3, 2, 1'b1);
        chk("first_read", 64'(readCount), 64'(1));
        chk("first_hit",  64'(hitCount),  64'(1));
        chk("first_miss", 64'(missCount), 64'(0));
        chk("first_busy", 64'(busy),      64'(0));

        // Table of single commands
        do_clear();
        e_rd = 0; e_wr = 0; e_hs = 0; e_ms = 0; e_inv = 0; e_pr = 0;
        p0 = n_print;
        for (int i = 0; i < 14; i++) begin
            push(vt[i].code, vt[i].addr);
            if (vt[i].iss) begin
                do_txn(vt[i].code, vt[i].addr, i % 3, 1 + (i % 3), vt[i].hit);
            end else begin
                seen = 1'b0;
                repeat (4) begin
                    @(negedge clock);
                    seen = seen | reqValid;
                end
                chk("vec_noreq", 64'(seen), 64'(0));
                if (vt[i].code == 4'd9) m_print++;
                else                    m_inv = sat(m_inv);
            end
            e_rd += vt[i].rd; e_wr += vt[i].wr; e_hs += vt[i].hs;
            e_ms += vt[i].ms; e_inv += vt[i].inv; e_pr += vt[i].pr;
            chk("vec_read",    64'(readCount),    64'(e_rd));
            chk("vec_write",   64'(writeCount),   64'(e_wr));
            chk("vec_hit",     64'(hitCount),     64'(e_hs));
            chk("vec_miss",    64'(missCount),    64'(e_ms));
            chk("vec_invalid", 64'(invalidCount), 64'(e_inv));
            chk("vec_print",   64'(n_print),      64'(p0 + e_pr));
            chk("vec_busy",    64'(busy),         64'(0));
        end

        // Write miss, ifetch hit, snoop hit
        do_clear();
        push(4'd1, 32'h0000_0A00);
        push(4'd2, 32'h0000_0B00);
        push(4'd4, 32'h0000_0C00);
        do_txn(4'd1, 32'h0000_0A00, 0, 1, 1'b0);
        do_txn(4'd2, 32'h0000_0B00, 0, 2, 1'b1);
        do_txn(4'd4, 32'h0000_0C00, 1, 1, 1'b1);
        chk("mix_write", 64'(writeCount), 64'(1));
        chk("mix_read",  64'(readCount),  64'(1));
        chk("mix_hit",   64'(hitCount),   64'(1));
        chk("mix_miss",  64'(missCount),  64'(1));

        // Illegal codes never issue; print pulses once
        p0 = n_print;
        push(4'd7, 32'h0000_0D00);
        push(4'd12, 32'h0000_0E00);
        push(4'd9, 32'h0);
        m_inv = sat(m_inv); m_inv = sat(m_inv); m_print++;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            seen = seen | reqValid;
        end
        chk("illegal_noreq",   64'(seen),         64'(0));
        chk("illegal_count",   64'(invalidCount), 64'(2));
        chk("print_one_pulse", 64'(n_print),      64'(p0 + 1));
        chk("illegal_busy",    64'(busy),         64'(0));

        // Clear waits behind an outstanding read
        pc = n_clear;
        push(4'd0, 32'h0000_3000);
        push(4'd8, 32'h0);
        do_txn(4'd0, 32'h0000_3000, 3, 2, 1'b0);
        chk("clr_not_yet", 64'(n_clear),   64'(pc));
        chk("clr_pre_read", 64'(readCount), 64'(2));
        repeat (3) @(negedge clock);
        chk("clr_once", 64'(n_clear), 64'(pc + 1));
        m_zero();
        chk_model("clr_after");

        // Fill to full with one in flight, then wrap the pointers
        for (int i = 0; i < 5; i++) push(f_op[i], f_ad[i]);
        chk("full_ready", 64'(cmdReady), 64'(0));
        chk("full_busy",  64'(busy),     64'(1));
        do_txn(f_op[0], f_ad[0], 2, 1, 1'b1);
        chk("held_ready", 64'(cmdReady), 64'(0));
        push(f_op[5], f_ad[5]);
        for (int i = 1; i < 6; i++) do_txn(f_op[i], f_ad[i], 0, 1, 1'(i % 2));
        repeat (2) @(negedge clock);
        chk_model("wrap");
        chk("wrap_busy", 64'(busy), 64'(0));

        // Saturation
        for (int i = 0; i < 260; i++) begin
            push(4'd0, 32'(i * 64));
            do_txn(4'd0, 32'(i * 64), 0, 1, 1'b1);
        end
        chk("sat_read", 64'(readCount), 64'(255));
        chk("sat_hit",  64'(hitCount),  64'(255));
        chk_model("sat");
        do_clear();

        // Randomized traffic against the queue model
        n_legal = 0; n_resp = 0; prod_done = 1'b0; rnd_abort = 1'b0;
        fork
            begin : producer
                int r;
                logic [3:0]  c;
                logic [31:0] a;
                for (int i = 0; i < 150 && !rnd_abort; i++) begin
                    r = int'($urandom_range(0, 19));
                    if (r < 14)       c = 4'(r % 7);
                    else if (r < 16)  c = 4'd9;
                    else if (r == 16) c = 4'd7;
                    else              c = 4'($urandom_range(10, 15));
                    a = $urandom();
                    if ($urandom_range(0, 3) == 0) @(negedge clock);
                    push(c, a);
                    if (c <= 4'd6) begin
                        exp_q.push_back('{op: c, addr: a});
                        n_legal++;
                    end else if (c == 4'd9) begin
                        m_print++;
                    end else begin
                        m_inv = sat(m_inv);
                    end
                end
                prod_done = 1'b1;
            end
            begin : responder
                txn_t cur;
                int   d;
                bit   h;
                int   cyc;
                cyc = 0;
                while (!(prod_done && n_resp == n_legal) && cyc < 20000 && !rnd_abort) begin
                    @(negedge clock);
                    cyc++;
                    respValid = 1'b0;
                    if (reqValid) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL rnd_extra_req: reqValid=1 op=%0d, expected no request", reqOp);
                            rnd_abort = 1'b1;
                        end else begin
                            chk("rnd_op",   64'(reqOp),      64'(exp_q[0].op));
                            chk("rnd_addr", 64'(reqAddress), 64'(exp_q[0].addr));
                            if ($urandom_range(0, 2) != 0) begin
                                cur = exp_q.pop_front();
                                reqReady = 1'b1;
                                @(negedge clock);
                                cyc++;
                                reqReady = 1'b0;
                                d = int'($urandom_range(1, 4));
                                repeat (d - 1) begin
                                    @(negedge clock);
                                    cyc++;
                                end
                                h = 1'($urandom_range(0, 1));
                                respValid = 1'b1; respHit = h;
                                @(negedge clock);
                                cyc++;
                                respValid = 1'b0;
                                m_resp(cur.op, h);
                                n_resp++;
                            end else begin
                                respValid = ($urandom_range(0, 3) == 0);
                                respHit   = 1'($urandom_range(0, 1));
                            end
                        end
                    end
                end
                respValid = 1'b0;
                if (!(prod_done && n_resp == n_legal)) begin
                    total++; bad++;
                    $display("FAIL rnd_timeout: %0d of %0d requests completed", n_resp, n_legal);
                    rnd_abort = 1'b1;
                end
            end
        join
        repeat (6) @(negedge clock);
        chk_model("rnd");
        chk("rnd_print",    64'(n_print),  64'(m_print));
        chk("rnd_busy",     64'(busy),     64'(0));
        chk("rnd_reqValid", 64'(reqValid), 64'(0));

        // Asynchronous reset while a request is being offered
        push(4'd1, 32'hCAFE_0000);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            seen = reqValid;
        end
        chk("arst_pre_valid", 64'(reqValid), 64'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid_drop", 64'(reqValid), 64'(0));
        chk("arst_busy_drop",  64'(busy),     64'(0));
        @(negedge clock);
        reset = 1'b0;
        m_zero();
        repeat (3) @(negedge clock);
        chk("arst_reqValid", 64'(reqValid), 64'(0));
        chk("arst_busy",     64'(busy),     64'(0));
        chk("arst_cmdReady", 64'(cmdReady), 64'(1));
        chk_model("arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
